// File: rtl/cnt8_ctrl_if.sv
// Command/status bundle for cnt8_ctrl: command inputs plus count/state outputs.
// master drives commands; slave (the counter) returns count, state and flags.
interface cnt8_ctrl_if;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ST_W  = 3;

  logic             i_load;
  logic             i_inc;
  logic             i_dec;
  logic [CNT_W-1:0] i_d_in;
  logic [CNT_W-1:0] o_cnt;
  logic [ST_W-1:0]  o_state;
  logic             o_busy;
  logic             o_wrap;

  modport master (
    output i_load, i_inc, i_dec, i_d_in,
    input  o_cnt, o_state, o_busy, o_wrap
  );

  modport slave (
    input  i_load, i_inc, i_dec, i_d_in,
    output o_cnt, o_state, o_busy, o_wrap
  );
endinterface

// File: rtl/cnt8_ctrl.sv
// 8-bit load/two-step inc/dec counter controller with priority command decode.
// Define CNT8_SATURATE_EN to saturate at 00/FF instead of wrapping modulo 256.
module cnt8_ctrl (
  input  logic        clk,
  input  logic        reset,
  cnt8_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned ST_W  = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'b000;
  localparam logic [ST_W-1:0] ST_LOAD = 3'b001;
  localparam logic [ST_W-1:0] ST_INC  = 3'b010;
  localparam logic [ST_W-1:0] ST_INC2 = 3'b011;
  localparam logic [ST_W-1:0] ST_DEC  = 3'b100;
  localparam logic [ST_W-1:0] ST_DEC2 = 3'b101;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};

  logic [ST_W-1:0]  r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;

  logic [ST_W-1:0]  w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;

  // State register, count and wrap flag; reset aborts any pending second step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_MIN;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Next state from command priority, then count update driven by next state.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = 1'b0;

    case (r_state)
      ST_IDLE, ST_LOAD, ST_INC2, ST_DEC2: begin
        if (bus.i_load)     w_state_nxt = ST_LOAD;
        else if (bus.i_inc) w_state_nxt = ST_INC;
        else if (bus.i_dec) w_state_nxt = ST_DEC;
        else                w_state_nxt = ST_IDLE;
      end
      ST_INC:  w_state_nxt = ST_INC2;
      ST_DEC:  w_state_nxt = ST_DEC2;
      default: w_state_nxt = ST_IDLE;
    endcase

    case (w_state_nxt)
      ST_LOAD: w_cnt_nxt = bus.i_d_in;
      ST_INC, ST_INC2: begin
        if (r_cnt == CNT_MAX) begin
          w_wrap_nxt = 1'b1;
`ifdef CNT8_SATURATE_EN
          w_cnt_nxt  = CNT_MAX;
`else
          w_cnt_nxt  = CNT_MIN;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DEC, ST_DEC2: begin
        if (r_cnt == CNT_MIN) begin
          w_wrap_nxt = 1'b1;
`ifdef CNT8_SATURATE_EN
          w_cnt_nxt  = CNT_MIN;
`else
          w_cnt_nxt  = CNT_MAX;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  assign bus.o_cnt   = r_cnt;
  assign bus.o_state = r_state;
  assign bus.o_wrap  = r_wrap;
  assign bus.o_busy  = (r_state == ST_INC) || (r_state == ST_DEC);

endmodule

// File: tb/tb_cnt8_ctrl.sv
// Scoreboard bench for cnt8_ctrl: directed scenarios then random commands,
// predicted by a step-count model and checked by an independent monitor.
module tb_cnt8_ctrl;
  logic clk;
  logic reset;

  cnt8_ctrl_if bus ();

  cnt8_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned state;
    int unsigned cnt;
    bit          busy;
    bit          wrap;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Model: count value as an integer plus a pending second-step direction.
  int m_cnt  = 0;
  int m_pend = 0;

  function automatic void m_step(input int dir, output int cnt, output bit wrap);
    int sum;
    sum = m_cnt + dir;
    if (sum >= 0 && sum <= 255) begin
      cnt  = sum;
      wrap = 1'b0;
    end else begin
      wrap = 1'b1;
`ifdef CNT8_SATURATE_EN
      cnt  = m_cnt;
`else
      cnt  = (sum + 256) % 256;
`endif
    end
  endfunction

  // Apply one cycle of stimulus and queue the response expected after the edge.
  task automatic drive(input bit rst, input bit ld, input bit inc, input bit dec,
                       input logic [7:0] d);
    exp_t e;
    int   c;
    bit   w;
    @(negedge clk);
    reset      = rst;
    bus.i_load = ld;
    bus.i_inc  = inc;
    bus.i_dec  = dec;
    bus.i_d_in = d;
    w = 1'b0;
    if (rst) begin
      m_cnt = 0; m_pend = 0; e.state = 0;
    end else if (m_pend != 0) begin
      m_step(m_pend, c, w); m_cnt = c;
      e.state = (m_pend > 0) ? 3 : 5;
      m_pend = 0;
    end else if (ld) begin
      m_cnt = int'(d); e.state = 1;
    end else if (inc) begin
      m_step(1, c, w); m_cnt = c; e.state = 2; m_pend = 1;
    end else if (dec) begin
      m_step(-1, c, w); m_cnt = c; e.state = 4; m_pend = -1;
    end else begin
      e.state = 0;
    end
    e.cnt  = m_cnt;
    e.busy = (m_pend != 0);
    e.wrap = w;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs just after each edge that has a prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (int'(bus.o_state) != e.state) begin
        n_miss++;
        $display("FAIL state vec=%0d got=%0d exp=%0d", n_vec, bus.o_state, e.state);
      end
      if (int'(bus.o_cnt) != e.cnt) begin
        n_miss++;
        $display("FAIL cnt vec=%0d got=%02h exp=%02h", n_vec, bus.o_cnt, e.cnt);
      end
      if (bus.o_busy != e.busy) begin
        n_miss++;
        $display("FAIL busy vec=%0d got=%0b exp=%0b", n_vec, bus.o_busy, e.busy);
      end
      if (bus.o_wrap != e.wrap) begin
        n_miss++;
        $display("FAIL wrap vec=%0d got=%0b exp=%0b", n_vec, bus.o_wrap, e.wrap);
      end
    end
  end

  initial begin
    logic [7:0] edge_vals [4];
    int r;
    edge_vals[0] = 8'h00; edge_vals[1] = 8'hFF;
    edge_vals[2] = 8'hFE; edge_vals[3] = 8'h01;

    reset = 1'b1; bus.i_load = 1'b0; bus.i_inc = 1'b0; bus.i_dec = 1'b0;
    bus.i_d_in = 8'h00;

    drive(1, 0, 0, 0, 8'h00);
    drive(1, 1, 1, 1, 8'h77);
    // load A5 then idle
    drive(0, 1, 0, 0, 8'hA5);
    drive(0, 0, 0, 0, 8'h00);
    // increment from 10
    drive(0, 1, 0, 0, 8'h10);
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    // wrap up from FE
    drive(0, 1, 0, 0, 8'hFE);
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    // wrap down from 00
    drive(0, 1, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    // priority and commands ignored while busy
    drive(0, 1, 1, 1, 8'h3C);
    drive(0, 0, 1, 1, 8'h00);
    drive(0, 1, 0, 1, 8'h99);
    drive(0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    // reset in INC aborts second step
    drive(0, 1, 0, 0, 8'h40);
    drive(0, 0, 1, 0, 8'h00);
    drive(1, 0, 1, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    // back-to-back increments chained from INC2
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      drive(r < 3, r < 25, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            ($urandom_range(0, 1) == 0) ? edge_vals[$urandom_range(0, 3)]
                                        : 8'($urandom));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/cnt8_ctrl.md
CNT8_CTRL -- requirements
Module: cnt8_ctrl

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-002 Port clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port reset  input  1  synchronous active-high reset.
REQ-004 Port i_load  input  1  load command; highest priority.
REQ-005 Port i_inc  input  1  two-step increment command; middle priority.
REQ-006 Port i_dec  input  1  two-step decrement command; lowest priority.
REQ-007 Port i_d_in  input  8  load value.
REQ-008 Port o_cnt  output  8  registered count value.
REQ-009 Port o_state  output  3  current state code.
REQ-010 Port o_busy  output  1  high in INC or DEC; commands are ignored in that cycle.
REQ-011 Port o_wrap  output  1  one-cycle flag; high when the last o_cnt update overflowed or underflowed.

Function
REQ-012 State codes SHALL be IDLE=000, LOAD=001, INC=010, INC2=011, DEC=100, DEC2=101.
REQ-013 In IDLE, LOAD, INC2 and DEC2, next state SHALL be decided by command priority: i_load -> LOAD, else i_inc -> INC, else i_dec -> DEC, else IDLE.
REQ-014 INC SHALL go to INC2 and DEC SHALL go to DEC2 unconditionally; all commands are ignored in INC and DEC.
REQ-015 Unused codes 110/111 SHALL go to IDLE on the next edge; o_cnt holds and o_wrap=0 for that edge.
REQ-016 o_cnt SHALL update on the same edge as the state, based on the next state: LOAD -> i_d_in; INC/INC2 -> o_cnt+1; DEC/DEC2 -> o_cnt-1; IDLE -> hold.
REQ-017 Command-to-output latency SHALL be one edge; a command sampled at edge t is visible on o_state and o_cnt after edge t.
REQ-018 One i_inc or i_dec acceptance SHALL change o_cnt by exactly 2 over two consecutive cycles.
REQ-019 Simultaneous commands SHALL be resolved by priority only: load+inc+dec -> LOAD; inc+dec -> INC.
REQ-020 Arithmetic SHALL be modulo 256 by default: FF+1=00 and 00-1=FF.
REQ-021 o_wrap SHALL be registered and go high on the edge producing a wrap or saturation event; otherwise it is 0, including after LOAD.
REQ-022 o_busy SHALL be combinational from state: 1 iff state is INC or DEC.
REQ-023 o_state SHALL be the state register itself, with no decoding delay.

Reset
REQ-024 When reset=1 at an edge, the block SHALL set state=IDLE, o_cnt=8'h00 and o_wrap=0; this gives o_busy=0.
REQ-025 Reset SHALL override all commands and any in-progress two-step operation, including INC and DEC; no second step follows.
REQ-026 After reset deasserts, the first command SHALL be sampled at the next edge.

Configuration
REQ-027 Macro CNT8_SATURATE_EN SHALL select the counting mode.
REQ-028 Without CNT8_SATURATE_EN, counting SHALL wrap modulo 256 and o_wrap SHALL flag each wrap.
REQ-029 With CNT8_SATURATE_EN, an increment at FF SHALL hold FF and a decrement at 00 SHALL hold 00.
REQ-030 With CNT8_SATURATE_EN, o_wrap SHALL flag each blocked step.
REQ-031 With CNT8_SATURATE_EN, state sequencing SHALL be identical to the default build.

Verification
REQ-032 Load: reset, then i_load=1, i_d_in=A5 for 1 cycle -> o_state=001, o_cnt=A5; next cycle o_state=000, o_cnt=A5.
REQ-033 Increment: o_cnt=10, i_inc pulse -> INC with o_cnt=11 and o_busy=1, then INC2 with o_cnt=12 and o_busy=0, then IDLE.
REQ-034 Wrap up: load FE, then i_inc pulse -> o_cnt FF then 00, o_wrap=1 only in the 00 cycle; with macro -> FF then FF, o_wrap=1 in the second cycle.
REQ-035 Wrap down: o_cnt=00, i_dec pulse -> FF then FE (o_wrap=1 in the FF cycle); with macro -> 00, 00 with o_wrap=1 in both cycles.
REQ-036 Priority: i_load=i_inc=i_dec=1 with i_d_in=3C -> LOAD, o_cnt=3C; i_inc=i_dec=1 -> INC; i_load asserted while in INC -> ignored, INC2 follows.
REQ-037 Reset during INC (o_cnt=41) -> next edge IDLE, o_cnt=00, o_wrap=0, no INC2.
